// File: rtl/decoder_scan_n_if.sv
// Bus bundle for decoder_scan_n: mode/address/scan controls in, active-low selects and status out.
interface decoder_scan_n_if #(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned DWELL_W = 8
);
  localparam int unsigned NOUT = 1 << ADDR_W;

  logic               Cs;
  logic               mode;
  logic [ADDR_W-1:0]  A;
  logic               start;
  logic               stop;
  logic [DWELL_W-1:0] dwell;
  logic [NOUT-1:0]    Y;
  logic [ADDR_W-1:0]  cur_addr;
  logic               busy;
  logic               wrap;

  modport master (
    output Cs, mode, A, start, stop, dwell,
    input  Y, cur_addr, busy, wrap
  );

  modport slave (
    input  Cs, mode, A, start, stop, dwell,
    output Y, cur_addr, busy, wrap
  );
endinterface

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N active-low decoder with chip-select blanking and an autonomous
// scan sequencer that walks the strobe through all outputs with a programmable dwell.
module decoder_scan_n #(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned DWELL_W = 8
) (
  input logic             clk,
  input logic             rst,
  decoder_scan_n_if.slave bus
);
  localparam int unsigned NOUT = 1 << ADDR_W;

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_inc;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [NOUT-1:0]    y_q;
  logic               busy_q;
  logic               wrap_q;

  function automatic logic [NOUT-1:0] onehot_n(input logic [ADDR_W-1:0] a);
    logic [NOUT-1:0] y;
    y    = '1;
    y[a] = 1'b0;
    return y;
  endfunction

  always_comb begin
    addr_inc = addr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      y_q     <= '1;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          addr_q <= bus.A;
          y_q    <= bus.Cs ? '1 : onehot_n(bus.A);
          // stop overrides a coincident start
          if (bus.start && bus.mode && !bus.stop) begin
            state_q <= StScan;
            cnt_q   <= bus.dwell;
            dwell_q <= bus.dwell;
            busy_q  <= 1'b1;
          end
        end
        StScan: begin
          if (bus.stop || !bus.mode) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            addr_q  <= bus.A;
            y_q     <= bus.Cs ? '1 : onehot_n(bus.A);
          end else if (bus.Cs) begin
            // pause: address and dwell count frozen, outputs blanked
            y_q <= '1;
          end else if (cnt_q == '0) begin
            addr_q <= addr_inc;
            cnt_q  <= dwell_q;
            y_q    <= onehot_n(addr_inc);
            wrap_q <= &addr_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            y_q   <= onehot_n(addr_q);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.Y        = y_q;
  assign bus.cur_addr = addr_q;
  assign bus.busy     = busy_q;
  assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n: one 2-bit/8-bit instance and one 3-bit/4-bit instance.
module tb_decoder_scan_n;
  logic clk = 1'b0;
  logic rst2, rst3;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decoder_scan_n_if #(.ADDR_W(2), .DWELL_W(8)) b2 ();
  decoder_scan_n_if #(.ADDR_W(3), .DWELL_W(4)) b3 ();

  decoder_scan_n #(.ADDR_W(2), .DWELL_W(8)) u_d2 (.clk(clk), .rst(rst2), .bus(b2.slave));
  decoder_scan_n #(.ADDR_W(3), .DWELL_W(4)) u_d3 (.clk(clk), .rst(rst3), .bus(b3.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_scan2(input logic [1:0] a, input logic [7:0] d);
    b2.mode  = 1'b1;
    b2.A     = a;
    b2.dwell = d;
    b2.start = 1'b1;
    step();
    b2.start = 1'b0;
  endtask

  task automatic stop_scan2();
    b2.stop = 1'b1;
    step();
    b2.stop = 1'b0;
    b2.mode = 1'b0;
  endtask

  initial begin
    int         ea;
    logic [3:0] e4;
    logic [7:0] e8;

    rst2 = 1'b1; rst3 = 1'b1;
    b2.Cs = 1'b0; b2.mode = 1'b0; b2.A = '0; b2.start = 1'b0; b2.stop = 1'b0; b2.dwell = '0;
    b3.Cs = 1'b0; b3.mode = 1'b0; b3.A = '0; b3.start = 1'b0; b3.stop = 1'b0; b3.dwell = '0;
    step();
    chk("rst_y", b2.Y, 4'hF);
    chk("rst_addr", b2.cur_addr, 0);
    chk("rst_busy", b2.busy, 0);
    chk("rst_wrap", b2.wrap, 0);
    rst2 = 1'b0;

    // direct decode
    b2.A = 2'd0; step(); chk("dir_a0", b2.Y, 4'hE);
    b2.A = 2'd1; step(); chk("dir_a1", b2.Y, 4'hD);
    b2.A = 2'd2; step(); chk("dir_a2", b2.Y, 4'hB);
    b2.A = 2'd3; step(); chk("dir_a3", b2.Y, 4'h7);
    chk("dir_addr3", b2.cur_addr, 3);
    b2.Cs = 1'b1; step(); chk("dir_cs", b2.Y, 4'hF);
    b2.Cs = 1'b0;
    b2.start = 1'b1; step(); b2.start = 1'b0;
    chk("start_mode0_ignored", b2.busy, 0);

    // scan, dwell=2 from address 1
    start_scan2(2'd1, 8'd2);
    chk("scan_busy", b2.busy, 1);
    chk("scan_entry_addr", b2.cur_addr, 1);
    chk("scan_entry_y", b2.Y, 4'hD);
    chk("scan_entry_wrap", b2.wrap, 0);
    for (int i = 1; i <= 21; i++) begin
      step();
      ea = (1 + i / 3) % 4;
      chk($sformatf("scan_d2_addr_%0d", i), b2.cur_addr, ea);
      chk($sformatf("scan_d2_wrap_%0d", i), b2.wrap, (i == 9 || i == 21) ? 1 : 0);
    end
    b2.A = 2'd2;
    stop_scan2();
    chk("stop_busy", b2.busy, 0);
    chk("stop_addr_tracks_a", b2.cur_addr, 2);
    chk("stop_wrap", b2.wrap, 0);

    // reset mid-scan
    start_scan2(2'd2, 8'd5);
    chk("pre_rst_addr", b2.cur_addr, 2);
    rst2 = 1'b1; step();
    chk("midrst_y", b2.Y, 4'hF);
    chk("midrst_addr", b2.cur_addr, 0);
    chk("midrst_busy", b2.busy, 0);
    chk("midrst_wrap", b2.wrap, 0);
    rst2 = 1'b0; b2.mode = 1'b0; b2.A = 2'd3; step();
    chk("post_rst_y", b2.Y, 4'h7);

    // fastest scan; start/A/dwell changes mid-scan must not disturb it
    start_scan2(2'd3, 8'd0);
    chk("fast_entry_addr", b2.cur_addr, 3);
    chk("fast_entry_nowrap", b2.wrap, 0);
    for (int i = 1; i <= 6; i++) begin
      if (i == 2) begin b2.A = 2'd1; b2.dwell = 8'd7; end
      b2.start = (i == 3);
      step();
      ea = (3 + i) % 4;
      e4 = 4'hF; e4[ea] = 1'b0;
      chk($sformatf("fast_addr_%0d", i), b2.cur_addr, ea);
      chk($sformatf("fast_y_%0d", i), b2.Y, e4);
      chk($sformatf("fast_wrap_%0d", i), b2.wrap, (ea == 0) ? 1 : 0);
    end
    b2.start = 1'b0;
    stop_scan2();

    // Cs pause with address 2, dwell counter 1
    start_scan2(2'd1, 8'd2);
    for (int i = 1; i <= 4; i++) step();
    chk("pause_pre_addr", b2.cur_addr, 2);
    b2.Cs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("pause_y_%0d", i), b2.Y, 4'hF);
      chk($sformatf("pause_addr_%0d", i), b2.cur_addr, 2);
    end
    chk("pause_busy", b2.busy, 1);
    b2.Cs = 1'b0;
    step(); chk("resume_addr_a", b2.cur_addr, 2); chk("resume_y_a", b2.Y, 4'hB);
    step(); chk("resume_addr_b", b2.cur_addr, 3); chk("resume_y_b", b2.Y, 4'h7);
    stop_scan2();

    // start and stop together
    b2.mode = 1'b1; b2.start = 1'b1; b2.stop = 1'b1; step();
    b2.start = 1'b0; b2.stop = 1'b0;
    chk("start_stop_busy", b2.busy, 0);
    step();
    chk("start_stop_busy2", b2.busy, 0);
    b2.mode = 1'b0;

    // wider instance: 8 outputs, dwell=15 (16 cycles per output)
    step();
    chk("w_rst_y", b3.Y, 8'hFF);
    chk("w_rst_busy", b3.busy, 0);
    rst3 = 1'b0;
    b3.A = 3'd5; step();
    chk("w_dir_y", b3.Y, 8'hDF);
    b3.mode = 1'b1; b3.A = 3'd6; b3.dwell = 4'd15; b3.start = 1'b1; step();
    b3.start = 1'b0; b3.A = 3'd0; b3.dwell = 4'd0;
    chk("w_entry_addr", b3.cur_addr, 6);
    chk("w_entry_busy", b3.busy, 1);
    chk("w_entry_wrap", b3.wrap, 0);
    for (int i = 1; i <= 40; i++) begin
      step();
      ea = (6 + i / 16) % 8;
      e8 = 8'hFF; e8[ea] = 1'b0;
      chk($sformatf("w_addr_%0d", i), b3.cur_addr, ea);
      chk($sformatf("w_y_%0d", i), b3.Y, e8);
      chk($sformatf("w_wrap_%0d", i), b3.wrap, (i == 32) ? 1 : 0);
    end
    b3.A = 3'd4; b3.stop = 1'b1; step();
    chk("w_stop_busy", b3.busy, 0);
    chk("w_stop_addr", b3.cur_addr, 4);
    chk("w_stop_y", b3.Y, 8'hEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
